// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared definitions for the VC weighted round-robin pop scheduler:
// arbiter state encoding and default datapath geometry.
package vc_arb_pkg;

  localparam int unsigned BW_DEF       = 6;
  localparam int unsigned LEN4_DEF     = 4;
  localparam int unsigned DEST_BIT_DEF = 4;

  typedef enum logic {
    SERVE_VC0 = 1'b0,
    SERVE_VC1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vc_wrr_arbiter_if.sv
// Bus between the two VC FIFOs, the destination pause flags and the arbiter.
// The slave side is the arbiter; the master side is whoever drives the FIFOs.
interface vc_wrr_arbiter_if
  import vc_arb_pkg::*;
#(
  parameter int unsigned BW   = BW_DEF,
  parameter int unsigned LEN4 = LEN4_DEF
);
  logic            VC0_empty;
  logic            VC1_empty;
  logic [BW-1:0]   VC0_data_out;
  logic [BW-1:0]   VC1_data_out;
  logic            D0_pause;
  logic            D1_pause;
  logic [LEN4-1:0] W0;
  logic [LEN4-1:0] W1;
  logic            VC0_pop;
  logic            VC1_pop;
  logic            valid_out;
  logic [BW-1:0]   data_out;
  logic            dest;

  modport slave (
    input  VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
    input  D0_pause, D1_pause, W0, W1,
    output VC0_pop, VC1_pop, valid_out, data_out, dest
  );

  modport master (
    output VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
    output D0_pause, D1_pause, W0, W1,
    input  VC0_pop, VC1_pop, valid_out, data_out, dest
  );
endinterface

// File: rtl/vc_wrr_arbiter_wrr_counter.sv
// Per-turn grant counter: tracks grants used in the current turn against the
// latched weight and flags turn end / single-grant turns for the arbiter FSM.
module wrr_counter #(
  parameter int unsigned LEN4 = 4
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            i_grant_pref,
  input  logic            i_grant_oth,
  input  logic [LEN4-1:0] i_w_pref,
  input  logic [LEN4-1:0] i_w_oth,
  output logic            o_turn_end,
  output logic            o_bounce
);
  localparam logic [LEN4-1:0] W_ONE  = {{(LEN4-1){1'b0}}, 1'b1};
  localparam logic [LEN4-1:0] W_ZERO = {LEN4{1'b0}};

  function automatic logic [LEN4-1:0] f_wmap(input logic [LEN4-1:0] w);
    f_wmap = (w == W_ZERO) ? W_ONE : w;
  endfunction

  logic [LEN4-1:0] r_cnt;
  logic [LEN4-1:0] r_wcur;
  logic            r_fresh;
  logic [LEN4-1:0] w_cnt_nxt;
  logic [LEN4-1:0] w_wcur_nxt;
  logic [LEN4-1:0] w_wcur_eff;
  logic [LEN4-1:0] w_w_pref_m;
  logic [LEN4-1:0] w_w_oth_m;
  logic [LEN4-1:0] w_cnt_p1;
  logic [LEN4:0]   w_cnt_inc;

  // Turn bookkeeping; the first cycle after reset uses the live VC0 weight.
  always_comb begin
    w_w_pref_m = f_wmap(i_w_pref);
    w_w_oth_m  = f_wmap(i_w_oth);
    w_wcur_eff = r_fresh ? w_w_pref_m : r_wcur;
    w_cnt_p1   = r_cnt + W_ONE;
    w_cnt_inc  = {1'b0, r_cnt} + {{LEN4{1'b0}}, 1'b1};
    o_turn_end = (w_cnt_inc >= {1'b0, w_wcur_eff});
    o_bounce   = (w_w_oth_m == W_ONE);
    w_cnt_nxt  = r_cnt;
    w_wcur_nxt = w_wcur_eff;
    if (i_grant_pref) begin
      if (o_turn_end) begin
        w_cnt_nxt  = W_ZERO;
        w_wcur_nxt = w_w_oth_m;
      end else begin
        w_cnt_nxt  = w_cnt_p1;
        w_wcur_nxt = w_wcur_eff;
      end
    end else if (i_grant_oth) begin
      if (o_bounce) begin
        w_cnt_nxt  = W_ZERO;
        w_wcur_nxt = w_w_pref_m;
      end else begin
        w_cnt_nxt  = W_ONE;
        w_wcur_nxt = w_w_oth_m;
      end
    end else begin
      w_cnt_nxt  = r_cnt;
      w_wcur_nxt = w_wcur_eff;
    end
  end

  // Counter and latched-weight registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt   <= W_ZERO;
      r_wcur  <= W_ONE;
      r_fresh <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_wcur  <= w_wcur_nxt;
      r_fresh <= 1'b0;
    end
  end
endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin pop scheduler for two VC FIFOs: combinational pop
// decision, registered valid/select, popped word presented one cycle later.
module vc_wrr_arbiter
  import vc_arb_pkg::*;
#(
  parameter int unsigned BW       = BW_DEF,
  parameter int unsigned LEN4     = LEN4_DEF,
  parameter int unsigned DEST_BIT = DEST_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  vc_wrr_arbiter_if.slave   bus
);
  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic            w_pause;
  logic            w_pref_empty;
  logic            w_oth_empty;
  logic            w_gnt_pref;
  logic            w_gnt_oth;
  logic            w_pop0;
  logic            w_pop1;
  logic            w_turn_end;
  logic            w_bounce;
  logic [LEN4-1:0] w_w_pref;
  logic [LEN4-1:0] w_w_oth;
  logic            r_valid;
  logic            r_sel;
  logic [BW-1:0]   w_data;

  // Grant: preferred VC first, then the other VC so no cycle is wasted.
  always_comb begin
    w_pause = bus.D0_pause | bus.D1_pause;
    if (r_state == SERVE_VC0) begin
      w_pref_empty = bus.VC0_empty;
      w_oth_empty  = bus.VC1_empty;
      w_w_pref     = bus.W0;
      w_w_oth      = bus.W1;
    end else begin
      w_pref_empty = bus.VC1_empty;
      w_oth_empty  = bus.VC0_empty;
      w_w_pref     = bus.W1;
      w_w_oth      = bus.W0;
    end
    w_gnt_pref = 1'b0;
    w_gnt_oth  = 1'b0;
    if (!reset_L || w_pause) begin
      w_gnt_pref = 1'b0;
      w_gnt_oth  = 1'b0;
    end else if (!w_pref_empty) begin
      w_gnt_pref = 1'b1;
    end else if (!w_oth_empty) begin
      w_gnt_oth = 1'b1;
    end else begin
      w_gnt_pref = 1'b0;
      w_gnt_oth  = 1'b0;
    end
    w_pop0 = (r_state == SERVE_VC0) ? w_gnt_pref : w_gnt_oth;
    w_pop1 = (r_state == SERVE_VC1) ? w_gnt_pref : w_gnt_oth;
  end

  wrr_counter #(.LEN4(LEN4)) u_wrr_counter (
    .clk          (clk),
    .reset_L      (reset_L),
    .i_grant_pref (w_gnt_pref),
    .i_grant_oth  (w_gnt_oth),
    .i_w_pref     (w_w_pref),
    .i_w_oth      (w_w_oth),
    .o_turn_end   (w_turn_end),
    .o_bounce     (w_bounce)
  );

  // Next preferred VC; a grant to a weight-1 other VC ends its turn at once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SERVE_VC0: begin
        if ((w_gnt_pref && w_turn_end) || (w_gnt_oth && !w_bounce)) begin
          w_state_nxt = SERVE_VC1;
        end else begin
          w_state_nxt = SERVE_VC0;
        end
      end
      SERVE_VC1: begin
        if ((w_gnt_pref && w_turn_end) || (w_gnt_oth && !w_bounce)) begin
          w_state_nxt = SERVE_VC0;
        end else begin
          w_state_nxt = SERVE_VC1;
        end
      end
      default: w_state_nxt = SERVE_VC0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= SERVE_VC0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pop decision registered; reset discards a word popped the cycle before.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_valid <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_valid <= w_pop0 | w_pop1;
      if (w_pop1) begin
        r_sel <= 1'b1;
      end else if (w_pop0) begin
        r_sel <= 1'b0;
      end else begin
        r_sel <= r_sel;
      end
    end
  end

  // FIFO read data is live the cycle after the pop, so only sel is registered.
  always_comb begin
    if (r_valid) begin
      w_data = r_sel ? bus.VC1_data_out : bus.VC0_data_out;
    end else begin
      w_data = {BW{1'b0}};
    end
  end

  assign bus.VC0_pop   = w_pop0;
  assign bus.VC1_pop   = w_pop1;
  assign bus.valid_out = r_valid;
  assign bus.data_out  = w_data;
  assign bus.dest      = w_data[DEST_BIT];
endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Bench for vc_wrr_arbiter: FIFO queues plus a quota-based turn model,
// directed scenarios followed by randomized traffic, pause and reset.
module tb_vc_wrr_arbiter;
  import vc_arb_pkg::*;

  localparam int BW       = 6;
  localparam int LEN4     = 4;
  localparam int DEST_BIT = 4;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  vc_wrr_arbiter_if #(.BW(BW), .LEN4(LEN4)) bus ();

  vc_wrr_arbiter #(.BW(BW), .LEN4(LEN4), .DEST_BIT(DEST_BIT)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0]   q0[$];
  logic [BW-1:0]   q1[$];
  logic [BW-1:0]   rd0 = '0;
  logic [BW-1:0]   rd1 = '0;
  logic            p0 = 1'b0;
  logic            p1 = 1'b0;
  logic [LEN4-1:0] w0v = 4'd1;
  logic [LEN4-1:0] w1v = 4'd1;
  int              glog[$];

  // Reference: preferred VC plus grants left in its turn (0 = not yet loaded).
  int              m_pref = 0;
  int              m_left = 0;
  bit              m_valid = 1'b0;
  logic [BW-1:0]   m_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int wmap(input logic [LEN4-1:0] w);
    return (w == 4'd0) ? 1 : int'(w);
  endfunction

  function automatic int wof(input int vc);
    return (vc == 1) ? wmap(w1v) : wmap(w0v);
  endfunction

  task automatic step(input logic rst_n_in);
    int            g;
    int            orig;
    int            sz[2];
    bit            nxt_valid;
    logic [BW-1:0] nxt_data;
    @(negedge clk);
    reset_L          = rst_n_in;
    bus.VC0_empty    = (q0.size() == 0);
    bus.VC1_empty    = (q1.size() == 0);
    bus.VC0_data_out = rd0;
    bus.VC1_data_out = rd1;
    bus.D0_pause     = p0;
    bus.D1_pause     = p1;
    bus.W0           = w0v;
    bus.W1           = w1v;
    #1;
    if (!rst_n_in) begin
      m_pref  = 0;
      m_left  = 0;
      m_valid = 1'b0;
      m_data  = '0;
    end
    if (rst_n_in && m_left == 0) begin
      m_pref = 0;
      m_left = wof(0);
    end
    sz[0] = q0.size();
    sz[1] = q1.size();
    g = -1;
    if (rst_n_in && !(p0 || p1)) begin
      if (sz[m_pref] > 0) g = m_pref;
      else if (sz[1 - m_pref] > 0) g = 1 - m_pref;
    end
    check_eq("vc0_pop", 32'(bus.VC0_pop), 32'(g == 0));
    check_eq("vc1_pop", 32'(bus.VC1_pop), 32'(g == 1));
    check_eq("valid_out", 32'(bus.valid_out), 32'(m_valid));
    check_eq("data_out", 32'(bus.data_out), 32'(m_data));
    check_eq("dest", 32'(bus.dest), 32'(m_valid & m_data[DEST_BIT]));
    glog.push_back(g);
    if (g >= 0 && g == m_pref) begin
      m_left--;
      if (m_left == 0) begin
        m_pref = 1 - m_pref;
        m_left = wof(m_pref);
      end
    end else if (g >= 0) begin
      orig   = m_pref;
      m_pref = g;
      m_left = wof(g) - 1;
      if (m_left == 0) begin
        m_pref = orig;
        m_left = wof(orig);
      end
    end
    nxt_valid = 1'b0;
    nxt_data  = '0;
    if (g == 0) begin
      rd0 = q0.pop_front();
      nxt_valid = 1'b1;
      nxt_data  = rd0;
    end else if (g == 1) begin
      rd1 = q1.pop_front();
      nxt_valid = 1'b1;
      nxt_data  = rd1;
    end
    @(posedge clk);
    m_valid = nxt_valid;
    m_data  = nxt_data;
  endtask

  task automatic do_reset();
    repeat (2) step(1'b0);
    q0.delete();
    q1.delete();
    p0 = 1'b0;
    p1 = 1'b0;
    glog.delete();
  endtask

  task automatic fill(input int n0, input int n1);
    for (int i = 0; i < n0; i++) q0.push_back(BW'($urandom));
    for (int i = 0; i < n1; i++) q1.push_back(BW'($urandom));
  endtask

  initial begin
    int ones;
    int zeros;
    int pat31[8];
    int alt[4];
    pat31 = '{0, 0, 0, 1, 0, 0, 0, 1};
    alt   = '{0, 1, 0, 1};
    reset_L = 1'b1;
    #1 reset_L = 1'b0;

    // Reset values and 3:1 weighting.
    do_reset();
    w0v = 4'd3; w1v = 4'd1;
    fill(8, 8);
    repeat (18) step(1'b1);
    for (int i = 0; i < 8; i++) check_eq($sformatf("w31_order%0d", i), 32'(glog[i]), 32'(pat31[i]));

    // Only VC1 has data: work-conserving, never pops VC0.
    do_reset();
    w0v = 4'd2; w1v = 4'd2;
    fill(0, 4);
    repeat (6) step(1'b1);
    ones = 0; zeros = 0;
    foreach (glog[i]) begin
      if (glog[i] == 1) ones++;
      if (glog[i] == 0) zeros++;
    end
    check_eq("vc1_only_pops", 32'(ones), 32'd4);
    check_eq("vc1_only_vc0", 32'(zeros), 32'd0);

    // D1 pause across cycles 5..8.
    do_reset();
    w0v = 4'd2; w1v = 4'd3;
    fill(8, 8);
    for (int c = 1; c <= 16; c++) begin
      p1 = (c >= 5 && c <= 8);
      step(1'b1);
    end
    p1 = 1'b0;
    check_eq("pre_pause_pop", 32'(glog[3] >= 0), 32'd1);
    for (int i = 4; i < 8; i++) check_eq($sformatf("paused_pop%0d", i), 32'(glog[i]), 32'hFFFF_FFFF);

    // Destination bit.
    do_reset();
    q0.push_back(6'b010000);
    q0.push_back(6'b000011);
    repeat (4) step(1'b1);

    // Zero weights act as one: strict alternation.
    do_reset();
    w0v = 4'd0; w1v = 4'd0;
    fill(6, 6);
    repeat (8) step(1'b1);
    for (int i = 0; i < 4; i++) check_eq($sformatf("w00_alt%0d", i), 32'(glog[i]), 32'(alt[i]));

    // Reset in the middle of streaming, new W0 latched at release.
    do_reset();
    w0v = 4'd3; w1v = 4'd2;
    fill(10, 10);
    repeat (5) step(1'b1);
    step(1'b0);
    step(1'b0);
    w0v = 4'd2;
    glog.delete();
    repeat (8) step(1'b1);
    check_eq("post_reset_first", 32'(glog[0]), 32'd0);

    // Randomized traffic, pauses, weight changes and occasional reset.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 45 && q0.size() < 12) q0.push_back(BW'($urandom));
      if ($urandom_range(0, 99) < 45 && q1.size() < 12) q1.push_back(BW'($urandom));
      p0 = ($urandom_range(0, 99) < 7);
      p1 = ($urandom_range(0, 99) < 7);
      if ($urandom_range(0, 19) == 0) begin
        w0v = LEN4'($urandom_range(0, 15));
        w1v = LEN4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 149) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
